// File: rtl/keccak_masked_pkg.sv
// keccak_masked_pkg: shared index constants, FSM state type and helpers for the masked chi datapath
package keccak_masked_pkg;
    localparam int LANE_W  = 64;
    localparam int NUM_X   = 5;
    localparam int NUM_Y   = 5;
    localparam int STATE_W = LANE_W * NUM_X * NUM_Y;
    localparam int ROW_CNT = LANE_W * NUM_Y;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chi_state_e;

    function automatic int rand_bits_per_sbox(input int d);
        return 10 * (d * (d + 1) / 2);
    endfunction

    // Flat position of share s, lane x of row r (r = 64*y + z)
    function automatic int bit_idx(input int s, input int x, input int r);
        return STATE_W * s + LANE_W * (NUM_X * (r / LANE_W) + x) + r % LANE_W;
    endfunction
endpackage

// File: rtl/keccak_sbox_pini.sv
// keccak_sbox_pini: one masked chi row, domain-oriented AND gadgets, result registered (1-cycle latency)
module keccak_sbox_pini
    import keccak_masked_pkg::*;
#(
    parameter int security_order = 1
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [5*(security_order+1)-1:0]                  row_in,
    input  logic [rand_bits_per_sbox(security_order)-1:0]    rand_in,
    output logic [5*(security_order+1)-1:0]                  row_out
);
    localparam int NS = security_order + 1;

    logic [5*NS-1:0] row_d, row_q;

    // Share bit x of row: a_x ^ (~a_{x+1} & a_{x+2}); inversion lives on share 0 only.
    // Each share pair spends two fresh bits per AND: one masks the cross terms, one re-masks both outputs.
    always_comb begin
        int p;
        row_d = row_in;
        p = 0;
        for (int x = 0; x < 5; x++)
            for (int i = 0; i < NS; i++)
                row_d[5*i+x] ^= (row_in[5*i+(x+1)%5] ^ (i == 0)) & row_in[5*i+(x+2)%5];
        for (int i = 0; i < NS; i++)
            for (int j = i + 1; j < NS; j++) begin
                for (int x = 0; x < 5; x++) begin
                    row_d[5*i+x] ^= ((row_in[5*i+(x+1)%5] ^ (i == 0)) & row_in[5*j+(x+2)%5])
                                    ^ rand_in[10*p+x] ^ rand_in[10*p+5+x];
                    row_d[5*j+x] ^= (row_in[5*j+(x+1)%5] & row_in[5*i+(x+2)%5])
                                    ^ rand_in[10*p+x] ^ rand_in[10*p+5+x];
                end
                p++;
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) row_q <= '0;
        else        row_q <= row_d;

    assign row_out = row_q;
endmodule

// File: rtl/keccak_chi_seq.sv
// keccak_chi_seq: sequential masked Keccak chi, SBOX_PAR rows per randomness-gated issue.
// Optional KECCAK_CHI_IOTA_FUSE_EN folds the iota round constant into share 0 of lane (0,0).
module keccak_chi_seq
    import keccak_masked_pkg::*;
#(
    parameter int security_order = 1,
    parameter int SBOX_PAR       = 64
) (
    input  logic                                                     clk,
    input  logic                                                     rst_n,
    input  logic                                                     start,
    input  logic [STATE_W*(security_order+1)-1:0]                    state_in,
    input  logic                                                     rand_valid,
    input  logic [SBOX_PAR*rand_bits_per_sbox(security_order)-1:0]  rand_data,
`ifdef KECCAK_CHI_IOTA_FUSE_EN
    input  logic [LANE_W-1:0]                                        rc,
`endif
    output logic                                                     rand_ready,
    output logic                                                     busy,
    output logic                                                     done,
    output logic [STATE_W*(security_order+1)-1:0]                    state_out
);
    localparam int NS  = security_order + 1;
    localparam int SW  = STATE_W * NS;
    localparam int RB  = rand_bits_per_sbox(security_order);
    localparam int NCH = ROW_CNT / SBOX_PAR;
    localparam int CW  = $clog2(NCH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

    chi_state_e      fsm_d, fsm_q;
    logic [CW-1:0]   cnt_d, cnt_q, wb_cnt_d, wb_cnt_q;
    logic            wb_valid_d, wb_valid_q;
    logic [SW-1:0]   data_d, data_q;
    logic [5*NS-1:0] sb_in  [SBOX_PAR];
    logic [5*NS-1:0] sb_out [SBOX_PAR];
`ifdef KECCAK_CHI_IOTA_FUSE_EN
    logic [LANE_W-1:0] rc_d, rc_q;
`endif

    always_comb begin
        sb_in = '{default: '0};
        for (int k = 0; k < SBOX_PAR; k++)
            for (int s = 0; s < NS; s++)
                for (int x = 0; x < 5; x++)
                    sb_in[k][5*s+x] = data_q[bit_idx(s, x, int'(cnt_q) * SBOX_PAR + k)];
    end

    for (genvar g = 0; g < SBOX_PAR; g++) begin : g_sbox
        keccak_sbox_pini #(.security_order(security_order)) u_sbox (
            .clk     (clk),
            .rst_n   (rst_n),
            .row_in  (sb_in[g]),
            .rand_in (rand_data[RB*g +: RB]),
            .row_out (sb_out[g])
        );
    end

    always_comb begin
        int r;
        fsm_d      = fsm_q;
        cnt_d      = cnt_q;
        wb_cnt_d   = cnt_q;
        wb_valid_d = 1'b0;
        data_d     = data_q;
        rand_ready = 1'b0;
        r          = 0;
`ifdef KECCAK_CHI_IOTA_FUSE_EN
        rc_d       = rc_q;
`endif
        unique case (fsm_q)
            IDLE: if (start) begin
                fsm_d  = RUN;
                cnt_d  = '0;
                data_d = state_in;
`ifdef KECCAK_CHI_IOTA_FUSE_EN
                rc_d   = rc;
`endif
            end
            RUN: if (rand_valid) begin
                rand_ready = 1'b1;
                wb_valid_d = 1'b1;
                cnt_d      = cnt_q + CW'(1);
                fsm_d      = (cnt_q == LAST_CNT) ? DRAIN : RUN;
            end
            DRAIN: fsm_d = wb_valid_q ? DRAIN : DONE;
            DONE:  fsm_d = IDLE;
        endcase
        // Writeback targets the previous chunk, disjoint from the one issuing now
        if (wb_valid_q)
            for (int k = 0; k < SBOX_PAR; k++) begin
                r = int'(wb_cnt_q) * SBOX_PAR + k;
                for (int s = 0; s < NS; s++)
                    for (int x = 0; x < 5; x++)
`ifdef KECCAK_CHI_IOTA_FUSE_EN
                        data_d[bit_idx(s, x, r)] = sb_out[k][5*s+x]
                            ^ (s == 0 && x == 0 && r < LANE_W && rc_q[r % LANE_W]);
`else
                        data_d[bit_idx(s, x, r)] = sb_out[k][5*s+x];
`endif
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            fsm_q      <= IDLE;
            cnt_q      <= '0;
            wb_cnt_q   <= '0;
            wb_valid_q <= 1'b0;
            data_q     <= '0;
`ifdef KECCAK_CHI_IOTA_FUSE_EN
            rc_q       <= '0;
`endif
        end else begin
            fsm_q      <= fsm_d;
            cnt_q      <= cnt_d;
            wb_cnt_q   <= wb_cnt_d;
            wb_valid_q <= wb_valid_d;
            data_q     <= data_d;
`ifdef KECCAK_CHI_IOTA_FUSE_EN
            rc_q       <= rc_d;
`endif
        end

    assign busy      = fsm_q != IDLE;
    assign done      = fsm_q == DONE;
    assign state_out = data_q;
endmodule

// File: tb/tb_keccak_chi_seq.sv
// tb_keccak_chi_seq: directed checks of the masked chi sequencer (d=1, SBOX_PAR=64)
module tb_keccak_chi_seq;
    localparam int D  = 1;
    localparam int NS = D + 1;
    localparam int SP = 64;
    localparam int SW = 1600 * NS;
    localparam int RW = SP * 10 * (D * (D + 1) / 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rand_valid = 1'b0;
    logic          rand_ready, busy, done;
    logic [SW-1:0] state_in = '0;
    logic [SW-1:0] state_out;
    logic [RW-1:0] rand_data = '0;
`ifdef KECCAK_CHI_IOTA_FUSE_EN
    logic [63:0]   rc = '0;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keccak_chi_seq #(.security_order(D), .SBOX_PAR(SP)) dut (
`ifdef KECCAK_CHI_IOTA_FUSE_EN
        .rc         (rc),
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .state_in   (state_in),
        .rand_valid (rand_valid),
        .rand_data  (rand_data),
        .rand_ready (rand_ready),
        .busy       (busy),
        .done       (done),
        .state_out  (state_out)
    );

    function automatic logic [1599:0] chi_ref(input logic [1599:0] a);
        logic [1599:0] o;
        o = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                o[64*(5*y+x) +: 64] = a[64*(5*y+x) +: 64]
                    ^ (~a[64*(5*y+(x+1)%5) +: 64] & a[64*(5*y+(x+2)%5) +: 64]);
        return o;
    endfunction

    function automatic logic [1599:0] unmask(input logic [SW-1:0] v);
        logic [1599:0] u;
        u = '0;
        for (int s = 0; s < NS; s++) u ^= v[1600*s +: 1600];
        return u;
    endfunction

    function automatic logic [1599:0] rnd_state();
        logic [1599:0] v;
        for (int i = 0; i < 50; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [RW-1:0] rnd_rand();
        logic [RW-1:0] v;
        for (int i = 0; i < RW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Runs one job for a fixed 40-cycle window; cyc stays -1 if done never rises
    task automatic do_run(input logic [1599:0] unm, input logic [1599:0] m, input int stall_at,
                          input int stall_len, input logic [63:0] start_mask,
                          output int cyc, output int rrc, output int dn);
        int stalled;
        state_in = {m, unm ^ m};
        @(negedge clk);
        start = 1'b1;
        rand_valid = 1'b1;
        rand_data = rnd_rand();
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = -1;
        rrc = 0;
        dn = 0;
        stalled = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = start_mask[n];
            if (rrc == stall_at && stalled < stall_len) begin
                rand_valid = 1'b0;
                stalled++;
            end else begin
                rand_valid = 1'b1;
                rand_data = rnd_rand();
            end
            #1;
            if (rand_ready) rrc++;
            @(posedge clk);
            #1;
            if (done) begin
                dn++;
                if (cyc < 0) cyc = n;
            end
        end
        start = 1'b0;
        rand_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rand_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (rand_ready !== 1'b0) begin errors++; $display("FAIL reset_rand_ready got %b want 0", rand_ready); end
        checks++; if (state_out !== '0) begin errors++; $display("FAIL reset_state got nonzero want 0"); end
        rand_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int cyc, rrc, dn;
        do_run('0, '0, -1, 0, '0, cyc, rrc, dn);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL zero_latency got %0d want 7", cyc); end
        checks++; if (rrc !== 5) begin errors++; $display("FAIL zero_rand_ready got %0d want 5", rrc); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL zero_done_pulses got %0d want 1", dn); end
        checks++; if (unmask(state_out) !== '0) begin errors++; $display("FAIL zero_result got %h want 0", unmask(state_out)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after got %b want 0", busy); end
    endtask

    task automatic test_lanes();
        int cyc, rrc, dn;
        logic [1599:0] unm, exp;
        // lane(2,0)=1s: chi gives lane0 = 0^(~0&1) = 1s, lane2 = 1^(~0&0) = 1s, rest 0
        unm = '0;
        unm[128 +: 64] = '1;
        exp = '0;
        exp[0 +: 64] = '1;
        exp[128 +: 64] = '1;
        do_run(unm, rnd_state(), -1, 0, '0, cyc, rrc, dn);
        checks++; if (unmask(state_out) !== exp) begin errors++; $display("FAIL lane2_result got %h want %h", unmask(state_out), exp); end
        checks++; if (cyc !== 7) begin errors++; $display("FAIL lane2_latency got %0d want 7", cyc); end
        // All-ones is a fixed point of chi
        unm = '1;
        do_run(unm, rnd_state(), -1, 0, '0, cyc, rrc, dn);
        checks++; if (unmask(state_out) !== unm) begin errors++; $display("FAIL ones_result got %h want all ones", unmask(state_out)); end
        // Single bit in lane(0,0) z=0 also lands in lane(3,0) via ~a4 & a0
        unm = '0;
        unm[0] = 1'b1;
        exp = '0;
        exp[0] = 1'b1;
        exp[192] = 1'b1;
        do_run(unm, rnd_state(), -1, 0, '0, cyc, rrc, dn);
        checks++; if (unmask(state_out) !== exp) begin errors++; $display("FAIL bit0_result got %h want %h", unmask(state_out), exp); end
        // Last row of the last chunk: lane(0,4) z=63 -> bits 1343 and 1535
        unm = '0;
        unm[1343] = 1'b1;
        exp = '0;
        exp[1343] = 1'b1;
        exp[1535] = 1'b1;
        do_run(unm, rnd_state(), -1, 0, '0, cyc, rrc, dn);
        checks++; if (unmask(state_out) !== exp) begin errors++; $display("FAIL lastrow_result got %h want %h", unmask(state_out), exp); end
    endtask

    task automatic test_stall();
        int cyc, rrc, dn;
        logic [1599:0] unm;
        unm = rnd_state();
        do_run(unm, rnd_state(), 2, 3, '0, cyc, rrc, dn);
        checks++; if (cyc !== 10) begin errors++; $display("FAIL stall_latency got %0d want 10", cyc); end
        checks++; if (rrc !== 5) begin errors++; $display("FAIL stall_rand_ready got %0d want 5", rrc); end
        checks++; if (unmask(state_out) !== chi_ref(unm)) begin errors++; $display("FAIL stall_result got %h want %h", unmask(state_out), chi_ref(unm)); end
    endtask

    task automatic test_start_ignored();
        int cyc, rrc, dn;
        logic [1599:0] unm;
        logic [SW-1:0] held;
        logic [63:0] mask;
        unm = rnd_state();
        mask = '0;
        mask[3] = 1'b1;
        mask[8] = 1'b1;
        do_run(unm, rnd_state(), -1, 0, mask, cyc, rrc, dn);
        checks++; if (dn !== 1) begin errors++; $display("FAIL ignore_done_pulses got %0d want 1", dn); end
        checks++; if (cyc !== 7) begin errors++; $display("FAIL ignore_latency got %0d want 7", cyc); end
        checks++; if (unmask(state_out) !== chi_ref(unm)) begin errors++; $display("FAIL ignore_result got %h want %h", unmask(state_out), chi_ref(unm)); end
        held = state_out;
        state_in = {rnd_state(), rnd_state()};
        repeat (5) @(posedge clk);
        #1;
        checks++; if (state_out !== held) begin errors++; $display("FAIL hold_result got %h want %h", unmask(state_out), unmask(held)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int cyc, rrc, dn;
        logic [1599:0] unm, m;
        unm = rnd_state();
        m = rnd_state();
        state_in = {m, unm ^ m};
        @(negedge clk);
        start = 1'b1;
        rand_valid = 1'b1;
        rand_data = rnd_rand();
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (rand_ready !== 1'b0) begin errors++; $display("FAIL midrst_rand_ready got %b want 0", rand_ready); end
        checks++; if (state_out !== '0) begin errors++; $display("FAIL midrst_state got nonzero want 0"); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        rand_valid = 1'b0;
        checks++; if (dn !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dn); end
        unm = rnd_state();
        do_run(unm, rnd_state(), -1, 0, '0, cyc, rrc, dn);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL midrst_rerun_latency got %0d want 7", cyc); end
        checks++; if (unmask(state_out) !== chi_ref(unm)) begin errors++; $display("FAIL midrst_rerun_result got %h want %h", unmask(state_out), chi_ref(unm)); end
    endtask

`ifdef KECCAK_CHI_IOTA_FUSE_EN
    task automatic test_iota();
        int cyc, rrc, dn;
        logic [1599:0] exp;
        exp = '0;
        exp[0] = 1'b1;
        rc = 64'h0000000000000001;
        do_run('0, rnd_state(), -1, 0, '0, cyc, rrc, dn);
        rc = '0;
        checks++; if (unmask(state_out) !== exp) begin errors++; $display("FAIL iota_result got %h want %h", unmask(state_out), exp); end
        checks++; if (cyc !== 7) begin errors++; $display("FAIL iota_latency got %0d want 7", cyc); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_lanes();
        test_stall();
        test_start_ignored();
        test_reset_mid();
`ifdef KECCAK_CHI_IOTA_FUSE_EN
        test_iota();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
